bk_operand_packer: RTL and testbench
====================================

BK_OPERAND_PACKER -- requirements
Module: bk_operand_packer

Interface
REQ-001 Parameter OPW, default 12: operand width in bits; SHALL be a multiple of NW.
REQ-002 Parameter NW, default 4: input beat (nibble) width in bits.
REQ-003 Parameter DEPTH, default 2: output FIFO entries, power of two, >=2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  beat valid.
REQ-007 in_ready  output  1  beat accepted when in_valid&&in_ready.
REQ-008 in_sof  input  1  marks the first beat of an operand pair.
REQ-009 in_data  input  NW  beat payload.
REQ-010 out_valid  output  1  packed pair available.
REQ-011 out_ready  input  1  downstream adder stage takes pair on out_valid&&out_ready.
REQ-012 out_pair  output  2*OPW  interleaved operands: bit 2i = A[i], bit 2i+1 = B[i].
REQ-013 frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-014 Pair = 2*OPW/NW beats (6 at defaults): first OPW/NW beats carry A LSB-nibble first, remaining beats carry B LSB-nibble first.
REQ-015 FSM states: IDLE (wait for beat with in_sof=1), LOAD_A, LOAD_B; beats without in_sof in IDLE SHALL be accepted and dropped with frame_err=1.
REQ-016 in_sof=1 accepted in LOAD_A/LOAD_B SHALL discard the partial pair, pulse frame_err, and restart at beat 0 with the current beat as A nibble 0.
REQ-017 On the last B beat the assembled, interleaved pair SHALL be written to the FIFO in the same cycle; FSM returns to IDLE.
REQ-018 Latency: pair visible on out_pair/out_valid the cycle after its last beat is accepted (FIFO registered, no combinational in->out path).
REQ-019 in_ready SHALL be 0 only when the FSM is on a last B beat and the FIFO is full with no pop this cycle; otherwise 1.
REQ-020 Simultaneous push and pop on a full FIFO SHALL succeed (count unchanged); on empty, no bypass.
REQ-021 out_pair SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 FIFO pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-023 During rst: FSM=IDLE, beat counter=0, FIFO empty, out_valid=0, out_pair=0, frame_err=0, in_ready=1 from the first cycle after rst deasserts.
REQ-024 rst asserted mid-pair SHALL discard the partial pair and all FIFO contents; no output emitted.

Configuration
REQ-025 Macro BK_PACKER_ERRCNT_EN defined: extra output err_count (8 bits) SHALL count frame_err pulses, saturating at 255, cleared by rst.
REQ-026 Macro undefined: err_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package bk_pkg SHALL hold OPW/NW defaults, beats-per-pair constant, FSM state enum, and the interleave function (A,B -> pair).
REQ-028 One sub-module, bk_pair_fifo (DEPTH x 2*OPW, synchronous, registered output), SHALL implement the output buffer.

Verification
REQ-029 Beats sof=1: 0x5,0x3,0x1 then 0x2,0x4,0x6 (A=0x135, B=0x642), out_ready=1 -> one cycle after beat 6, out_valid=1, out_pair = interleave(0x135,0x642).
REQ-030 Three back-to-back pairs with out_ready=0 -> two stored, in_ready=0 on third pair's last beat until out_ready=1; pairs emerge in order, none lost.
REQ-031 Pair aborted by sof=1 at beat 4 -> frame_err pulse, partial discarded, restarted pair output correctly; only one pair emitted.
REQ-032 Beat without sof in IDLE -> dropped, frame_err=1 one cycle, FSM stays IDLE.
REQ-033 rst asserted at beat 3 with one pair in FIFO -> out_valid=0 next cycle, no stale pair after reset.
REQ-034 With BK_PACKER_ERRCNT_EN: 300 framing errors -> err_count=255; rst -> 0.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared constants, FSM state type and the A/B bit-interleave helper for the operand packer.
package bk_pkg;
    localparam int OPW_DEF   = 12;
    localparam int NW_DEF    = 4;
    localparam int BEATS_DEF = 2 * OPW_DEF / NW_DEF;
    localparam int OPW_MAX   = 64;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;

    // Fixed max width so the helper can live in the package; callers cast to their width.
    function automatic logic [2*OPW_MAX-1:0] interleave(input logic [OPW_MAX-1:0] a,
                                                        input logic [OPW_MAX-1:0] b);
        logic [2*OPW_MAX-1:0] p;
        p = '0;
        for (int i = 0; i < OPW_MAX; i++) begin
            p[2*i]   = a[i];
            p[2*i+1] = b[i];
        end
        return p;
    endfunction
endpackage

// File: rtl/bk_operand_packer_if.sv
// Beat input / packed-pair output bundle for bk_operand_packer.
interface bk_operand_packer_if
    import bk_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int NW  = NW_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic            in_sof;
    logic [NW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [2*OPW-1:0] out_pair;
    logic            frame_err;

    modport master (output in_valid, in_sof, in_data, out_ready,
                    input  in_ready, out_valid, out_pair, frame_err);
    modport slave  (input  in_valid, in_sof, in_data, out_ready,
                    output in_ready, out_valid, out_pair, frame_err);
endinterface

// File: rtl/bk_pair_fifo.sv
// Synchronous DEPTH-entry pair buffer; output comes straight from storage flops, no bypass.
module bk_pair_fifo
    import bk_pkg::*;
#(
    parameter int W     = 2 * OPW_DEF,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign do_pop    = pop && (count != '0);
    // A full buffer still accepts when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/bk_operand_packer.sv
// Packs NW-bit beats into an interleaved A/B operand pair and buffers it for the adder stage.
// Optional BK_PACKER_ERRCNT_EN adds a saturating 8-bit framing-error counter output.
module bk_operand_packer
    import bk_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int NW    = NW_DEF,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    bk_operand_packer_if.slave bus
`ifdef BK_PACKER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam int BEATS   = 2 * OPW / NW;
    localparam int BEATS_A = OPW / NW;
    localparam int CW      = $clog2(BEATS);
    localparam int PW      = 2 * OPW;

    state_t        state, state_nxt;
    logic [CW-1:0] beat, beat_nxt;
    logic [PW-1:0] sr, sr_shift, pair;
    logic          accept, last_beat, push, pop, fifo_full, fe_nxt, fe_q;

    // LSB-nibble-first shift: after BEATS shifts A sits low, B high, and stale bits are gone.
    assign sr_shift  = {bus.in_data, sr[PW-1:NW]};
    assign pair      = PW'(interleave(OPW_MAX'(sr_shift[OPW-1:0]), OPW_MAX'(sr_shift[PW-1:OPW])));
    assign last_beat = (state == LOAD_B) && (beat == CW'(BEATS-1));
    assign pop       = bus.out_valid && bus.out_ready;
    assign bus.in_ready = !(last_beat && fifo_full && !bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign bus.frame_err = fe_q;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        push      = 1'b0;
        fe_nxt    = 1'b0;
        if (accept) begin
            if (bus.in_sof) begin
                fe_nxt    = (state != IDLE);
                beat_nxt  = CW'(1);
                state_nxt = (BEATS_A > 1) ? LOAD_A : LOAD_B;
            end else if (state == IDLE) begin
                fe_nxt = 1'b1;
            end else if (last_beat) begin
                push      = 1'b1;
                beat_nxt  = '0;
                state_nxt = IDLE;
            end else begin
                beat_nxt  = beat + CW'(1);
                state_nxt = (int'(beat) + 1 < BEATS_A) ? LOAD_A : LOAD_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            sr    <= '0;
            fe_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            fe_q  <= fe_nxt;
            if (accept) sr <= sr_shift;
        end
    end

`ifdef BK_PACKER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)                           err_count <= '0;
        else if (fe_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

    bk_pair_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(pair),
        .pop      (pop),
        .full     (fifo_full),
        .out_valid(bus.out_valid),
        .out_data (bus.out_pair)
    );
endmodule

// File: tb/tb_bk_operand_packer.sv
// Directed + random bench for bk_operand_packer against a beat-list / pair-queue reference model.
module tb_bk_operand_packer;
    localparam int OPW = 12, NW = 4, DEPTH = 2;
    localparam int BEATS = 2 * OPW / NW, BA = OPW / NW, PW = 2 * OPW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bk_operand_packer_if #(.OPW(OPW), .NW(NW)) bus ();
`ifdef BK_PACKER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    bk_operand_packer #(.OPW(OPW), .NW(NW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BK_PACKER_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    logic [PW-1:0] exp_q[$];  // pairs the DUT should be holding, oldest first
    int  part[$];             // nibbles of the pair in progress
    bit  in_pair = 0;
    bit  fe_exp  = 0;

    function automatic longint unsigned ref_pair(input longint unsigned a, input longint unsigned b);
        longint unsigned p = 0;
        for (int i = 0; i < OPW; i++)
            p |= (((a >> i) & 1) << (2 * i)) | (((b >> i) & 1) << (2 * i + 1));
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic beat_model(input bit s, input logic [NW-1:0] d);
        if (s) begin
            if (in_pair) fe_exp = 1;
            part.delete();
            part.push_back(int'(d));
            in_pair = 1;
        end else if (!in_pair) begin
            fe_exp = 1;
        end else begin
            part.push_back(int'(d));
            if (part.size() == BEATS) begin
                longint unsigned a = 0, b = 0;
                for (int i = 0; i < BA; i++) begin
                    a += longint'(part[i]) << (NW * i);
                    b += longint'(part[BA + i]) << (NW * i);
                end
                exp_q.push_back(PW'(ref_pair(a, b)));
                part.delete();
                in_pair = 0;
            end
        end
    endtask

    // One clock: drive at negedge, check the current DUT view, then advance the model past the next edge.
    task automatic step(input bit v, input bit s, input logic [NW-1:0] d, input bit ordy, output bit acc);
        bit last, rdy_exp, pop;
        @(negedge clk);
        bus.in_valid = v; bus.in_sof = s; bus.in_data = d; bus.out_ready = ordy;
        #1;
        last    = in_pair && (part.size() == BEATS - 1);
        rdy_exp = !(last && exp_q.size() == DEPTH && !ordy);
        chk("in_ready", bus.in_ready, rdy_exp);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_pair", bus.out_pair, exp_q[0]);
        chk("frame_err", bus.frame_err, fe_exp);
        acc    = v && rdy_exp;
        pop    = (exp_q.size() != 0) && ordy;
        fe_exp = 0;
        if (pop) void'(exp_q.pop_front());
        if (acc) beat_model(s, d);
    endtask

    task automatic send_beat(input bit s, input logic [NW-1:0] d, input bit ordy);
        bit acc = 0;
        int tries = 0;
        do begin
            step(1'b1, s, d, ordy, acc);
            tries++;
        end while (!acc && tries < 20);
        chk("beat_accept", acc, 1);
    endtask

    task automatic send_pair(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input bit ordy);
        logic [OPW-1:0] w;
        for (int i = 0; i < BEATS; i++) begin
            w = (i < BA) ? (a >> (NW * i)) : (b >> (NW * (i - BA)));
            send_beat(i == 0, w[NW-1:0], ordy);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ordy, acc);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pair", bus.out_pair, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        rst = 1'b0;
        exp_q.delete(); part.delete(); in_pair = 0; fe_exp = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        do_reset(2);

        // Single pair A=0x135 B=0x642 with the downstream always ready.
        send_pair(12'h135, 12'h642, 1'b1);
        idle(1, 1'b0);
        chk("req029_valid", bus.out_valid, 1);
        chk("req029_pair", bus.out_pair, 24'h292519);
        idle(2, 1'b1);

        // Three pairs into a stalled consumer: third last beat must wait.
        send_pair(12'hABC, 12'h123, 1'b0);
        send_pair(12'hFED, 12'h0F0, 1'b0);
        for (int i = 0; i < BEATS - 1; i++) send_beat(i == 0, NW'(i + 9), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'hE, 1'b0, acc);
        send_beat(1'b0, 4'hE, 1'b1);
        idle(4, 1'b1);

        // Abort at beat 4 by a fresh sof, then a full restarted pair.
        for (int i = 0; i < 4; i++) send_beat(i == 0, NW'(i + 1), 1'b1);
        send_pair(12'h5A5, 12'hC3C, 1'b1);
        idle(3, 1'b1);

        // Stray beat in IDLE, then a normal pair.
        send_beat(1'b0, 4'h7, 1'b1);
        idle(1, 1'b1);
        send_pair(12'h001, 12'h800, 1'b1);
        idle(2, 1'b1);

        // Reset mid-pair with one pair buffered.
        send_pair(12'h777, 12'h888, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(i == 0, NW'(i + 2), 1'b0);
        do_reset(1);
        idle(3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, NW'($urandom),
                 $urandom_range(0, 1) == 1, acc);
        idle(4, 1'b1);

`ifdef BK_PACKER_ERRCNT_EN
        do_reset(1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, NW'(i), 1'b1, acc);
        idle(1, 1'b1);
        chk("err_count_sat", err_count, 255);
        do_reset(1);
        chk("err_count_rst", err_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
